// File: rtl/gf180mcu_osu_sc_12t_latch_fifo.sv
// gf180mcu_osu_sc_12t_latch_fifo
//   WIDTH-bit, DEPTH-entry circular buffer with valid/ready handshakes on both
//   sides. With FLOWTHRU=1 an empty buffer is transparent: D reaches Q in the
//   same cycle, the way the original negative-level latch cell behaved.
//
// Ports
//   CLK    clock, all state updates on the rising edge
//   RST    synchronous active-high reset (pointers and COUNT only)
//   D      write data
//   DV     write valid
//   DR     write ready
//   Q      read data (head entry, or D during a flow-through cycle)
//   QV     read valid
//   QR     read ready
//   COUNT  number of stored entries
module gf180mcu_osu_sc_12t_latch_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter bit          FLOWTHRU = 1'b0,
  localparam int unsigned CW      = $clog2(DEPTH + 1),
  localparam int unsigned PW      = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  output logic             DR,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  input  logic             QR,
  output logic [CW-1:0]    COUNT
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;

  logic empty, full;
  logic bypass;
  logic push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Flow-through transfer: data goes D->Q and is never stored.
  assign bypass = FLOWTHRU && empty && DV && QR;

  always_comb begin
    DR = ~full;
    QV = ~empty;
    Q  = '0;
    if (FLOWTHRU) begin
      // When full, a simultaneous pop frees the slot being written.
      DR = ~full | QR;
      QV = ~empty | DV;
    end
    if (!empty) begin
      Q = mem_q[rp_q];
    end else if (FLOWTHRU) begin
      Q = D;
    end
  end

  assign push = DV & DR & ~bypass;
  assign pop  = QR & ~empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    // Arithmetic update lets an unknown handshake poison COUNT in 4-state sims.
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is not cleared by reset; a write in the reset cycle is discarded.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem_q[wp_q] <= D;
    end
  end

  assign COUNT = count_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_latch_fifo.sv
module tb_gf180mcu_osu_sc_12t_latch_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d   = 8'h00;
  logic       dv  = 1'b0;
  logic       qr  = 1'b0;

  // a: DEPTH=4 registered, b: DEPTH=3 registered, c: DEPTH=4 flow-through
  logic       dr_a, qv_a, dr_b, qv_b, dr_c, qv_c;
  logic [7:0] q_a, q_b, q_c;
  logic [2:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gf180mcu_osu_sc_12t_latch_fifo #(.WIDTH(8), .DEPTH(4), .FLOWTHRU(1'b0)) u_a (
    .CLK(clk), .RST(rst), .D(d), .DV(dv), .DR(dr_a), .Q(q_a), .QV(qv_a), .QR(qr),
    .COUNT(cnt_a)
  );

  gf180mcu_osu_sc_12t_latch_fifo #(.WIDTH(8), .DEPTH(3), .FLOWTHRU(1'b0)) u_b (
    .CLK(clk), .RST(rst), .D(d), .DV(dv), .DR(dr_b), .Q(q_b), .QV(qv_b), .QR(qr),
    .COUNT(cnt_b)
  );

  gf180mcu_osu_sc_12t_latch_fifo #(.WIDTH(8), .DEPTH(4), .FLOWTHRU(1'b1)) u_c (
    .CLK(clk), .RST(rst), .D(d), .DV(dv), .DR(dr_c), .Q(q_c), .QV(qv_c), .QR(qr),
    .COUNT(cnt_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic v, input logic [7:0] data, input logic rr);
    @(negedge clk);
    rst = r;
    dv  = v;
    d   = data;
    qr  = rr;
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] d;
    logic       qr;
    bit         chk;
    logic [2:0] count;
    logic       qv;
    logic       dr;
    logic [7:0] q;
  } vec_t;

  vec_t vecs[22];

  initial begin
    // Outputs are those seen during the cycle, before the edge that consumes the inputs.
    //            rst   dv    d      qr    chk  cnt   qv    dr    q
    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 0, 3'd0, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1, 3'd0, 1'b0, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 3'd0, 1'b0, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1, 3'd1, 1'b1, 1'b1, 8'h11};
    vecs[4]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1, 3'd2, 1'b1, 1'b1, 8'h11};
    vecs[5]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1, 3'd3, 1'b1, 1'b1, 8'h11};
    vecs[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1, 3'd4, 1'b1, 1'b0, 8'h11};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 3'd4, 1'b1, 1'b0, 8'h11};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 3'd3, 1'b1, 1'b1, 8'h22};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 3'd2, 1'b1, 1'b1, 8'h33};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 3'd1, 1'b1, 1'b1, 8'h44};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 3'd0, 1'b0, 1'b1, 8'h00};
    // simultaneous push/pop at COUNT=2
    vecs[12] = '{1'b0, 1'b1, 8'hC0, 1'b0, 1, 3'd0, 1'b0, 1'b1, 8'h00};
    vecs[13] = '{1'b0, 1'b1, 8'hC1, 1'b0, 1, 3'd1, 1'b1, 1'b1, 8'hC0};
    vecs[14] = '{1'b0, 1'b1, 8'hC2, 1'b1, 1, 3'd2, 1'b1, 1'b1, 8'hC0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 3'd2, 1'b1, 1'b1, 8'hC1};
    // reset mid-operation at COUNT=3
    vecs[16] = '{1'b0, 1'b1, 8'hD0, 1'b0, 1, 3'd2, 1'b1, 1'b1, 8'hC1};
    vecs[17] = '{1'b1, 1'b1, 8'hD1, 1'b1, 1, 3'd3, 1'b1, 1'b1, 8'hC1};
    vecs[18] = '{1'b0, 1'b1, 8'h99, 1'b0, 1, 3'd0, 1'b0, 1'b1, 8'h00};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 3'd1, 1'b1, 1'b1, 8'h99};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 3'd1, 1'b1, 1'b1, 8'h99};
    vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 3'd0, 1'b0, 1'b1, 8'h00};

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rst, vecs[i].dv, vecs[i].d, vecs[i].qr);
      if (vecs[i].chk) begin
        check($sformatf("v%0d count", i), 32'(cnt_a), 32'(vecs[i].count));
        check($sformatf("v%0d qv", i), 32'(qv_a), 32'(vecs[i].qv));
        check($sformatf("v%0d dr", i), 32'(dr_a), 32'(vecs[i].dr));
        check($sformatf("v%0d q", i), 32'(q_a), 32'(vecs[i].q));
      end
    end

    // Wrap-around on DEPTH=3: 4 rounds of push 3 / pop 3, data 0..11.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        drive(1'b0, 1'b1, 8'(r * 3 + k), 1'b0);
        check($sformatf("wrap r%0d k%0d dr", r, k), 32'(dr_b), 32'd1);
        check($sformatf("wrap r%0d k%0d push count", r, k), 32'(cnt_b), 32'(k));
      end
      for (int k = 0; k < 3; k++) begin
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        check($sformatf("wrap r%0d k%0d pop count", r, k), 32'(cnt_b), 32'(3 - k));
        check($sformatf("wrap r%0d k%0d q", r, k), 32'(q_b), 32'(r * 3 + k));
        check($sformatf("wrap r%0d k%0d qv", r, k), 32'(qv_b), 32'd1);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      check($sformatf("wrap r%0d empty", r), 32'(cnt_b), 32'd0);
    end

    // Flow-through: empty, DV=1, QR=1 -> same-cycle pass, nothing stored.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("ft empty qv", 32'(qv_c), 32'd0);
    check("ft empty q", 32'(q_c), 32'd0);
    drive(1'b0, 1'b1, 8'h7E, 1'b1);
    check("ft pass q", 32'(q_c), 32'h7E);
    check("ft pass qv", 32'(qv_c), 32'd1);
    check("ft pass count", 32'(cnt_c), 32'd0);
    drive(1'b0, 1'b1, 8'h7E, 1'b0);
    check("ft hold count before", 32'(cnt_c), 32'd0);
    check("ft hold q before", 32'(q_c), 32'h7E);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("ft hold count", 32'(cnt_c), 32'd1);
    check("ft hold q", 32'(q_c), 32'h7E);
    check("ft hold qv", 32'(qv_c), 32'd1);

    // Flow-through full: fill to 4, then push+pop together with DR held by QR.
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 8'(8'hE1 + k), 1'b0);
    drive(1'b0, 1'b1, 8'hE9, 1'b0);
    check("ft full dr qr0", 32'(dr_c), 32'd0);
    check("ft full count", 32'(cnt_c), 32'd4);
    drive(1'b0, 1'b1, 8'hE9, 1'b1);
    check("ft full dr qr1", 32'(dr_c), 32'd1);
    check("ft full head", 32'(q_c), 32'h7E);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("ft full count kept", 32'(cnt_c), 32'd4);
    check("ft full next head", 32'(q_c), 32'hE1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("ft drain %0d", k), 32'(q_c), (k == 3) ? 32'hE9 : 32'(8'hE1 + k));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("ft drained count", 32'(cnt_c), 32'd0);
    check("ft drained qv", 32'(qv_c), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
